sensor_debounce: RTL and testbench

- Input conditioner that sits directly upstream of the parking-lot entry/exit FSM.
- Takes the two raw, asynchronous gate-sensor signals (board push-buttons, already inverted to active-high) and synchronises and debounces each one.
- Drives clean A/B levels plus one-cycle edge pulses into the FSM.
- Keeps a saturating count of rejected glitches for board-level diagnostics on LEDR.

---
 rtl/sensor_debounce.sv | 90 +++++++++
 tb/tb_sensor_debounce.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sensor_debounce.sv
// Two-channel synchroniser and debouncer for the parking-gate sensors.
// Emits clean levels, one-cycle edge pulses and a saturating glitch count.
module sensor_debounce #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_raw,
  input  logic       b_raw,
  output logic       a,
  output logic       b,
  output logic       a_rise,
  output logic       a_fall,
  output logic       b_rise,
  output logic       b_fall,
  output logic [7:0] glitch_count
);

  // Counter value on the edge before the one that reaches STABLE_CYCLES.
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(STABLE_CYCLES - 1);

  logic [1:0]       raw;
  logic [1:0]       sync1_q, sync_q;
  logic [1:0]       lvl_q, lvl_d;
  logic [1:0]       rise_q, rise_d;
  logic [1:0]       fall_q, fall_d;
  logic [1:0]       glitch;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [7:0]       gcnt_q, gcnt_d;
  logic [8:0]       gsum;

  assign raw = {b_raw, a_raw};

  always_comb begin
    lvl_d  = lvl_q;
    rise_d = '0;
    fall_d = '0;
    glitch = '0;
    cnt_d  = cnt_q;
    for (int ch = 0; ch < 2; ch++) begin
      if (sync_q[ch] != lvl_q[ch]) begin
        if (cnt_q[ch] == LastCnt) begin
          lvl_d[ch]  = sync_q[ch];
          cnt_d[ch]  = '0;
          rise_d[ch] = sync_q[ch];
          fall_d[ch] = ~sync_q[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
        end
      end else if (cnt_q[ch] != '0) begin
        // Input fell back before acceptance: drop the attempt and log it.
        cnt_d[ch]  = '0;
        glitch[ch] = 1'b1;
      end
    end
    gsum   = {1'b0, gcnt_q} + 9'(glitch[0]) + 9'(glitch[1]);
    gcnt_d = gsum[8] ? 8'hFF : gsum[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync_q  <= '0;
      lvl_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      cnt_q   <= '{default: '0};
      gcnt_q  <= '0;
    end else begin
      sync1_q <= raw;
      sync_q  <= sync1_q;
      lvl_q   <= lvl_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign a            = lvl_q[0];
  assign b            = lvl_q[1];
  assign a_rise       = rise_q[0];
  assign a_fall       = fall_q[0];
  assign b_rise       = rise_q[1];
  assign b_fall       = fall_q[1];
  assign glitch_count = gcnt_q;

endmodule

// File: tb/tb_sensor_debounce.sv
// Scoreboard bench for sensor_debounce: stimulus queues expected pulse events,
// a negedge monitor pops and compares them whenever any pulse is seen.
module tb_sensor_debounce;

  logic       clk;
  logic       reset;
  logic       a_raw, b_raw;
  logic       a, b, a_rise, a_fall, b_rise, b_fall;
  logic [7:0] glitch_count;

  sensor_debounce #(
    .STABLE_CYCLES(4),
    .CNT_W        (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .a_raw       (a_raw),
    .b_raw       (b_raw),
    .a           (a),
    .b           (b),
    .a_rise      (a_rise),
    .a_fall      (a_fall),
    .b_rise      (b_rise),
    .b_fall      (b_fall),
    .glitch_count(glitch_count)
  );

  typedef struct {
    int         cyc;
    logic [3:0] pulses;  // {a_rise, a_fall, b_rise, b_fall}
  } exp_t;

  localparam logic [3:0] ARise = 4'b1000;
  localparam logic [3:0] AFall = 4'b0100;
  localparam logic [3:0] BRise = 4'b0010;
  localparam logic [3:0] BFall = 4'b0001;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Apply raw levels now; a change is accepted on edge 6 counted from the next posedge.
  task automatic drive(input logic ra, input logic rb, input logic [3:0] vec);
    exp_t e;
    a_raw = ra;
    b_raw = rb;
    if (vec != 4'b0000) begin
      e.cyc    = cyc + 6;
      e.pulses = vec;
      exp_q.push_back(e);
    end
  endtask

  task automatic glitch_pulse(input logic ga, input logic gb);
    a_raw = ga;
    b_raw = gb;
    step(1);
    a_raw = 1'b0;
    b_raw = 1'b0;
    step(6);
  endtask

  always @(negedge clk) begin
    logic [3:0] pv;
    exp_t       e;
    pv = {a_rise, a_fall, b_rise, b_fall};
    if (reset && pv != 4'b0000) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got %b at cycle %0d, required none", pv, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_vec", int'(pv), int'(e.pulses));
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    reset = 1'b0;
    a_raw = 1'b0;
    b_raw = 1'b0;
    step(3);
    check("rst_a", int'(a), 0);
    check("rst_b", int'(b), 0);
    check("rst_pulses", int'({a_rise, a_fall, b_rise, b_fall}), 0);
    check("rst_glitch", int'(glitch_count), 0);
    reset = 1'b1;
    step(2);

    // A rises and is held
    drive(1'b1, 1'b0, ARise);
    step(5);
    check("a_before_accept", int'(a), 0);
    step(1);
    check("a_at_edge6", int'(a), 1);
    step(4);
    check("b_idle", int'(b), 0);
    check("glitch_after_rise", int'(glitch_count), 0);
    drive(1'b0, 1'b0, AFall);
    step(10);
    check("a_after_fall", int'(a), 0);

    // Two-cycle glitch on A
    a_raw = 1'b1;
    step(2);
    a_raw = 1'b0;
    step(8);
    check("a_glitch_level", int'(a), 0);
    check("glitch_one", int'(glitch_count), 1);

    // Both channels together
    drive(1'b1, 1'b1, ARise | BRise);
    step(10);
    check("ab_high_a", int'(a), 1);
    check("ab_high_b", int'(b), 1);
    drive(1'b0, 1'b0, AFall | BFall);
    step(10);
    check("ab_low", int'({a, b}), 0);
    check("glitch_still_one", int'(glitch_count), 1);

    // Saturation of the glitch counter
    for (int i = 0; i < 250; i++) glitch_pulse(1'b1, 1'b0);
    check("glitch_251", int'(glitch_count), 251);
    glitch_pulse(1'b1, 1'b1);
    check("glitch_253_dual", int'(glitch_count), 253);
    glitch_pulse(1'b1, 1'b0);
    check("glitch_254", int'(glitch_count), 254);
    glitch_pulse(1'b1, 1'b1);
    check("glitch_sat_dual", int'(glitch_count), 255);
    for (int i = 0; i < 8; i++) glitch_pulse(1'b1, 1'b0);
    check("glitch_sat_hold", int'(glitch_count), 255);
    check("a_never_changed", int'(a), 0);

    // Reset pulse in the middle of a count
    a_raw = 1'b1;
    step(3);
    reset = 1'b0;
    #1;
    check("midrst_outputs", int'({a, b, a_rise, a_fall, b_rise, b_fall}), 0);
    check("midrst_glitch", int'(glitch_count), 0);
    step(1);
    reset = 1'b1;
    drive(1'b1, 1'b0, ARise);
    step(5);
    check("midrst_a_wait", int'(a), 0);
    step(1);
    check("midrst_a_accept", int'(a), 1);
    check("midrst_glitch_zero", int'(glitch_count), 0);
    step(4);
    drive(1'b0, 1'b0, AFall);
    step(10);

    // Car entry: A, A&B, B, none
    drive(1'b1, 1'b0, ARise);
    step(10);
    drive(1'b1, 1'b1, BRise);
    step(10);
    drive(1'b0, 1'b1, AFall);
    step(10);
    drive(1'b0, 1'b0, BFall);
    step(10);
    check("entry_levels", int'({a, b}), 0);
    check("entry_glitch", int'(glitch_count), 0);

    step(10);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
